// File: rtl/srq_beat_serializer.sv
// Pops one queue word and returns it as BEATS narrow beats, least-significant slice first.
// Optional beat parity: define SRQ_SER_PARITY_EN to build the XOR tree on beat_data.
module srq_beat_serializer #(
  parameter  int WIDTH  = 1024,
  parameter  int BEAT_W = 64,
  localparam int BEATS  = WIDTH / BEAT_W,
  localparam int IDX_W  = $clog2(BEATS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              q_valid,
  input  logic [WIDTH-1:0]  q_data,
  output logic              q_pop,
  input  logic              flush,
  output logic              beat_valid,
  input  logic              beat_ready,
  output logic [BEAT_W-1:0] beat_data,
  output logic              beat_last,
  output logic [IDX_W-1:0]  beat_idx,
  output logic              beat_parity,
  output logic              busy
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam logic [IDX_W-1:0] CNT_LAST = IDX_W'(BEATS - 1);
  localparam logic [IDX_W-1:0] CNT_ZERO = '0;
  localparam logic [IDX_W-1:0] CNT_ONE  = IDX_W'(1);

  state_t           state_r;
  state_t           state_nxt_s;
  logic [IDX_W-1:0] cnt_r;
  logic [IDX_W-1:0] cnt_nxt_s;
  logic [WIDTH-1:0] word_r;
  logic             at_last_s;
  logic             pop_s;

`ifdef SRQ_SER_PARITY_EN
  function automatic logic even_parity(input logic [BEAT_W-1:0] d);
    return ^d;
  endfunction
`endif

  assign at_last_s = (state_r == SEND) && (cnt_r == CNT_LAST);
  // Reload in the last-beat handshake cycle keeps back-to-back words gap-free.
  assign pop_s = rst && !flush && q_valid &&
                 ((state_r == IDLE) || (at_last_s && beat_ready));

  assign q_pop      = pop_s;
  assign beat_valid = (state_r == SEND);
  assign busy       = beat_valid;
  assign beat_last  = at_last_s;
  assign beat_idx   = cnt_r;
  assign beat_data  = word_r[int'(cnt_r) * BEAT_W +: BEAT_W];

`ifdef SRQ_SER_PARITY_EN
  assign beat_parity = beat_valid ? even_parity(beat_data) : 1'b0;
`else
  assign beat_parity = 1'b0;
`endif

  // Next-state and beat counter; flush overrides every other transition.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    if (flush) begin
      state_nxt_s = IDLE;
      cnt_nxt_s   = CNT_ZERO;
    end else begin
      case (state_r)
        IDLE: begin
          if (pop_s) begin
            state_nxt_s = SEND;
            cnt_nxt_s   = CNT_ZERO;
          end else begin
            state_nxt_s = IDLE;
            cnt_nxt_s   = CNT_ZERO;
          end
        end
        SEND: begin
          if (!beat_ready) begin
            cnt_nxt_s = cnt_r;
          end else if (cnt_r != CNT_LAST) begin
            cnt_nxt_s = cnt_r + CNT_ONE;
          end else if (pop_s) begin
            state_nxt_s = SEND;
            cnt_nxt_s   = CNT_ZERO;
          end else begin
            state_nxt_s = IDLE;
            cnt_nxt_s   = CNT_ZERO;
          end
        end
        default: begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = CNT_ZERO;
        end
      endcase
    end
  end

  // Control state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Word holding register; datapath only, contents meaningful while beat_valid.
  always_ff @(posedge clk) begin
    if (pop_s) begin
      word_r <= q_data;
    end else begin
      word_r <= word_r;
    end
  end

endmodule

// File: tb/tb_srq_beat_serializer.sv
// Self-checking bench for srq_beat_serializer: vector table, directed corner sequences,
// and random traffic checked against a beat-queue reference model.
module tb_srq_beat_serializer;

  localparam int WIDTH  = 1024;
  localparam int BEAT_W = 64;
  localparam int BEATS  = 16;

  logic              clk;
  logic              rst;
  logic              q_valid;
  logic [WIDTH-1:0]  q_data;
  logic              q_pop;
  logic              flush;
  logic              beat_valid;
  logic              beat_ready;
  logic [BEAT_W-1:0] beat_data;
  logic              beat_last;
  logic [3:0]        beat_idx;
  logic              beat_parity;
  logic              busy;

  srq_beat_serializer #(.WIDTH(WIDTH), .BEAT_W(BEAT_W)) dut (
    .clk(clk), .rst(rst), .q_valid(q_valid), .q_data(q_data), .q_pop(q_pop),
    .flush(flush), .beat_valid(beat_valid), .beat_ready(beat_ready),
    .beat_data(beat_data), .beat_last(beat_last), .beat_idx(beat_idx),
    .beat_parity(beat_parity), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Source words offered by the queue, and the model's beats still owed to the consumer.
  logic [WIDTH-1:0]  src[$];
  logic [BEAT_W-1:0] mb_data[$];
  int                mb_idx[$];

  typedef struct {
    logic qv, rdy, fl;
    logic pop, valid, last;
    logic [3:0] idx;
  } vec_t;
  vec_t tbl[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic exp_par(input logic [BEAT_W-1:0] d);
`ifdef SRQ_SER_PARITY_EN
    return ^d;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [WIDTH-1:0] mk_word(input logic [7:0] tag);
    logic [WIDTH-1:0] w;
    for (int k = 0; k < BEATS; k++) w[k*BEAT_W +: BEAT_W] = {tag, 48'h0, 8'(k)};
    return w;
  endfunction

  function automatic logic [WIDTH-1:0] rnd_word();
    logic [WIDTH-1:0] w;
    for (int k = 0; k < WIDTH/32; k++) w[k*32 +: 32] = $urandom;
    return w;
  endfunction

  task automatic drive(input logic qv, input logic rdy, input logic fl);
    q_valid    = qv && (src.size() > 0);
    q_data     = (src.size() > 0) ? src[0] : '0;
    beat_ready = rdy;
    flush      = fl;
  endtask

  // One cycle: check outputs mid-cycle against the model, then advance the model at the edge.
  task automatic tick();
    logic ev, ep;
    int   n;
    logic [WIDTH-1:0] w;
    @(negedge clk);
    n  = mb_data.size();
    ev = rst && (n > 0);
    ep = rst && !flush && q_valid && ((n == 0) || (beat_ready && n == 1));
    chk("q_pop", q_pop, ep);
    chk("beat_valid", beat_valid, ev);
    chk("busy", busy, ev);
    if (ev) begin
      chk("beat_data", beat_data, mb_data[0]);
      chk("beat_idx", beat_idx, mb_idx[0]);
      chk("beat_last", beat_last, mb_idx[0] == BEATS - 1);
      chk("beat_parity", beat_parity, exp_par(mb_data[0]));
    end else begin
      chk("idle_idx", beat_idx, 0);
      chk("idle_last", beat_last, 1'b0);
      chk("idle_parity", beat_parity, 1'b0);
    end
    @(posedge clk);
    if (rst) begin
      if (flush) begin
        mb_data.delete();
        mb_idx.delete();
      end else begin
        if (ev && beat_ready) begin
          void'(mb_data.pop_front());
          void'(mb_idx.pop_front());
        end
        if (ep) begin
          w = src.pop_front();
          for (int k = 0; k < BEATS; k++) begin
            mb_data.push_back(w[k*BEAT_W +: BEAT_W]);
            mb_idx.push_back(k);
          end
        end
      end
    end
    #1;
  endtask

  initial begin
    int nv;
    int stalled;
    logic rdy;

    tbl[0] = '{qv:1'b1, rdy:1'b1, fl:1'b0, pop:1'b1, valid:1'b0, last:1'b0, idx:4'd0};
    tbl[1] = '{qv:1'b1, rdy:1'b1, fl:1'b0, pop:1'b0, valid:1'b1, last:1'b0, idx:4'd0};
    tbl[2] = '{qv:1'b1, rdy:1'b1, fl:1'b0, pop:1'b0, valid:1'b1, last:1'b0, idx:4'd1};
    tbl[3] = '{qv:1'b1, rdy:1'b1, fl:1'b0, pop:1'b0, valid:1'b1, last:1'b0, idx:4'd2};
    tbl[4] = '{qv:1'b1, rdy:1'b1, fl:1'b0, pop:1'b0, valid:1'b1, last:1'b0, idx:4'd3};
    tbl[5] = '{qv:1'b1, rdy:1'b1, fl:1'b1, pop:1'b0, valid:1'b1, last:1'b0, idx:4'd4};
    tbl[6] = '{qv:1'b1, rdy:1'b1, fl:1'b0, pop:1'b1, valid:1'b0, last:1'b0, idx:4'd0};
    tbl[7] = '{qv:1'b1, rdy:1'b1, fl:1'b1, pop:1'b0, valid:1'b1, last:1'b0, idx:4'd0};
    tbl[8] = '{qv:1'b0, rdy:1'b1, fl:1'b0, pop:1'b0, valid:1'b0, last:1'b0, idx:4'd0};

    // Reset state, with q_valid high to show q_pop is gated by reset.
    rst = 1'b0;
    src.push_back(mk_word(8'h00));
    drive(1'b1, 1'b1, 1'b0);
    #1;
    chk("rst_pop", q_pop, 1'b0);
    chk("rst_valid", beat_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_idx", beat_idx, 0);
    chk("rst_last", beat_last, 1'b0);
    chk("rst_parity", beat_parity, 1'b0);
    @(posedge clk); #1;
    tick();
    rst = 1'b1;

    // Single word: beat k carries k; q_valid drops once the word is taken.
    for (int c = 0; c < 20; c++) begin
      drive(1'b1, 1'b1, 1'b0);
      #1;
      if (beat_valid && beat_idx == 4'd1) chk("parity_h1", beat_parity, exp_par(64'h1));
      if (beat_valid && beat_idx == 4'd3) chk("parity_h3", beat_parity, 1'b0);
      tick();
    end

    // Back-to-back: three words with ready held high.
    for (int i = 1; i <= 3; i++) src.push_back(mk_word(8'(i)));
    nv = 0;
    for (int c = 0; c < 52; c++) begin
      drive(1'b1, 1'b1, 1'b0);
      #1;
      if (beat_valid) nv++;
      tick();
    end
    chk("b2b_beats", nv, 48);

    // Back-pressure: five stalled cycles at beat 7.
    src.push_back(mk_word(8'h44));
    stalled = 0;
    for (int c = 0; c < 25; c++) begin
      rdy = 1'b1;
      if (mb_idx.size() > 0 && mb_idx[0] == 7 && stalled < 5) begin
        rdy = 1'b0;
        stalled++;
      end
      drive(1'b1, rdy, 1'b0);
      #1;
      if (!rdy) chk("bp_idx", beat_idx, 4'd7);
      tick();
    end
    chk("bp_stalls", stalled, 5);

    // Flush at beat 4, then re-pop: vector table.
    src.push_back(mk_word(8'h55));
    src.push_back(mk_word(8'h66));
    foreach (tbl[i]) begin
      drive(tbl[i].qv, tbl[i].rdy, tbl[i].fl);
      #1;
      chk("tbl_pop", q_pop, tbl[i].pop);
      chk("tbl_valid", beat_valid, tbl[i].valid);
      chk("tbl_idx", beat_idx, tbl[i].idx);
      chk("tbl_last", beat_last, tbl[i].last);
      tick();
    end

    // Reset mid-word at beat 9.
    src.delete();
    src.push_back(mk_word(8'h77));
    src.push_back(mk_word(8'h88));
    for (int c = 0; c < 40 && !(mb_idx.size() > 0 && mb_idx[0] == 9); c++) begin
      drive(1'b1, 1'b1, 1'b0);
      tick();
    end
    chk("pre_rst_idx", beat_idx, 4'd9);
    drive(1'b1, 1'b1, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_valid", beat_valid, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_pop", q_pop, 1'b0);
    mb_data.delete();
    mb_idx.delete();
    @(posedge clk); #1;
    tick();
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, 1'b1, 1'b0);
      tick();
    end

    // Random traffic against the model.
    for (int c = 0; c < 600; c++) begin
      if (src.size() < 2) src.push_back(rnd_word());
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
